regfile_write_arbiter: RTL and testbench

//  Shares the single RegisterFile write port (regWrite/Writereg/Writedata) between NREQ writeback sources (ALU, load unit, ...).

---
 rtl/regfile_write_arbiter_pkg.sv | 21 ++
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Register-file geometry shared by the writeback arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_write_arbiter_pkg;

    localparam int C_XLEN   = 32;
    localparam int C_REG_AW = 5;
    localparam int C_NREGS  = 32;
    localparam logic [C_REG_AW-1:0] C_REG_ZERO = 5'd0;

    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Writeback request bus and RegisterFile write-port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int XLEN   = C_XLEN,
    parameter int REG_AW = C_REG_AW
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*REG_AW-1:0] req_addr;
    logic [NREQ*XLEN-1:0]   req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   regWrite;
    logic [REG_AW-1:0]      Writereg;
    logic [XLEN-1:0]        Writedata;
    logic [C_NREGS-1:0]     pend_mask;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, regWrite, Writereg, Writedata, pend_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, regWrite, Writereg, Writedata, pend_mask
    );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter_rr_arbiter
// Description : Combinational round-robin arbiter, first request at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic      [N-1:0]  o_gnt,
    output logic      [PW-1:0] o_idx,
    output logic               o_any
);

    logic [PW-1:0] w_pos;

    // Scan from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_pos]) begin
                o_idx = w_pos;
                o_any = 1'b1;
            end
        end
        o_gnt = '0;
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin share of the RegisterFile write port, 1-cycle stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int XLEN   = C_XLEN,
    parameter int REG_AW = C_REG_AW
) (
    input  wire logic              clk,
    input  wire logic              rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    w_gnt;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic               w_xfer;
    logic               w_wr;
    logic [REG_AW-1:0]  w_addr;
    logic [XLEN-1:0]    w_data;
    logic [C_NREGS-1:0] w_pend;

    logic [PW-1:0]      r_ptr;
    logic               r_we;
    logic [REG_AW-1:0]  r_addr;
    logic [XLEN-1:0]    r_data;

    regfile_write_arbiter_rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // The stage never stalls, so any grant outside reset is a transfer.
    assign w_xfer        = rst & w_any;
    assign bus.req_ready = rst ? w_gnt : '0;
    assign w_addr        = bus.req_addr[int'(w_idx)*REG_AW +: REG_AW];
    assign w_data        = bus.req_data[int'(w_idx)*XLEN +: XLEN];
    assign w_wr          = w_xfer && (w_addr != REG_AW'(C_REG_ZERO));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_wr;
            if (w_xfer) begin
                r_ptr <= PW'(rr_next(32'(w_idx), NREQ));
            end
            if (w_wr) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
        end
    end

    for (genvar r = 0; r < C_NREGS; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign w_pend[r] = 1'b0;
        end else begin : g_decode
            logic w_hit;
            always_comb begin
                w_hit = r_we && (32'(r_addr) == r);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i] && (32'(bus.req_addr[i*REG_AW +: REG_AW]) == r)) begin
                        w_hit = 1'b1;
                    end
                end
            end
            assign w_pend[r] = rst & w_hit;
        end
    end

    assign bus.regWrite  = r_we;
    assign bus.Writereg  = r_addr;
    assign bus.Writedata = r_data;
    assign bus.pend_mask = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Vector table, mid-op reset sequence and randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int NREQ   = 2;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pend;
    } vec_t;

    vec_t tbl [15];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    // Reference model state
    int          m_ptr;
    logic        m_we, m_known;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [1:0]  rv;
    logic [4:0]  ra [NREQ];
    logic [31:0] rd [NREQ];
    logic        r_in;
    int          g;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_pend;

    initial begin
        apply(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        //             rst  v      a0     a1     d0            d1            rdy    we    wr     wd            pend
        tbl[0]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b00, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b00, 1'b0, 5'd0, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b01, 1'b0, 5'd0, 32'h0,        32'h6};
        tbl[3]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b10, 1'b1, 5'd1, 32'h11,       32'h6};
        tbl[4]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b01, 1'b1, 5'd2, 32'h22,       32'h6};
        tbl[5]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,       32'h22,       2'b10, 1'b1, 5'd1, 32'h11,       32'h6};
        tbl[6]  = '{1'b1, 2'b01, 5'd5, 5'd2, 32'hDEADBEEF, 32'h22,       2'b01, 1'b1, 5'd2, 32'h22,       32'h24};
        tbl[7]  = '{1'b1, 2'b00, 5'd5, 5'd2, 32'hDEADBEEF, 32'h22,       2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20};
        tbl[8]  = '{1'b1, 2'b10, 5'd5, 5'd0, 32'hDEADBEEF, 32'h1234,     2'b10, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[9]  = '{1'b1, 2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'h1234,     2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
        tbl[10] = '{1'b1, 2'b01, 5'd3, 5'd0, 32'h33,       32'h1234,     2'b01, 1'b0, 5'd5, 32'hDEADBEEF, 32'h8};
        tbl[11] = '{1'b1, 2'b11, 5'd7, 5'd7, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b10, 1'b1, 5'd3, 32'h33,       32'h88};
        tbl[12] = '{1'b1, 2'b01, 5'd7, 5'd7, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b01, 1'b1, 5'd7, 32'hBBBBBBBB, 32'h80};
        tbl[13] = '{1'b1, 2'b00, 5'd7, 5'd7, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b00, 1'b1, 5'd7, 32'hAAAAAAAA, 32'h80};
        tbl[14] = '{1'b1, 2'b00, 5'd7, 5'd7, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b00, 1'b0, 5'd7, 32'hAAAAAAAA, 32'h0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(tbl[i].rst, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            #1;
            check($sformatf("tbl%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d.regWrite", i),  32'(bus.regWrite),  32'(tbl[i].we));
            check($sformatf("tbl%0d.Writereg", i),  32'(bus.Writereg),  32'(tbl[i].wr));
            check($sformatf("tbl%0d.Writedata", i), bus.Writedata,      tbl[i].wd);
            check($sformatf("tbl%0d.pend_mask", i), bus.pend_mask,      tbl[i].pend);
        end

        // Mid-operation reset: pointer is 1 here; a staged write must vanish.
        @(negedge clk);
        apply(1'b1, 2'b01, 5'd9, 5'd0, 32'h99, 32'h0);
        #1;
        check("midrst.ready_a", 32'(bus.req_ready), 32'h1);
        check("midrst.pend_a",  bus.pend_mask,      32'h200);
        @(negedge clk);
        apply(1'b0, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
        #1;
        check("midrst.ready_in_rst", 32'(bus.req_ready), 32'h0);
        check("midrst.pend_in_rst",  bus.pend_mask,      32'h0);
        @(negedge clk);
        apply(1'b1, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
        #1;
        check("midrst.regWrite_after", 32'(bus.regWrite),  32'h0);
        check("midrst.Writereg_after", 32'(bus.Writereg),  32'h0);
        check("midrst.ready_ptr0",     32'(bus.req_ready), 32'h1);
        check("midrst.pend_after",     bus.pend_mask,      32'h6);

        // Randomized phase against a behavioural model
        m_known = 1'b0;
        m_ptr   = 0;
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
        rv      = '0;
        for (int s = 0; s < NREQ; s++) begin
            ra[s] = '0;
            rd[s] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            r_in = (cyc < 2) ? 1'b0 : ($urandom_range(0, 24) != 0);
            for (int s = 0; s < NREQ; s++) begin
                if (!rv[s] || $urandom_range(0, 7) == 0) begin
                    rv[s] = ($urandom_range(0, 2) != 0);
                    ra[s] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                    rd[s] = $urandom;
                end
            end
            @(negedge clk);
            apply(r_in, rv, ra[0], ra[1], rd[0], rd[1]);

            g = -1;
            exp_rdy = '0;
            if (r_in) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            exp_pend = '0;
            if (r_in) begin
                for (int s = 0; s < NREQ; s++) begin
                    if (rv[s]) exp_pend[ra[s]] = 1'b1;
                end
                if (m_we) exp_pend[m_reg] = 1'b1;
                exp_pend[0] = 1'b0;
            end

            #1;
            check($sformatf("rnd%0d.req_ready", cyc), 32'(bus.req_ready), 32'(exp_rdy));
            check($sformatf("rnd%0d.pend_mask", cyc), bus.pend_mask, exp_pend);
            if (m_known) begin
                check($sformatf("rnd%0d.regWrite", cyc), 32'(bus.regWrite), 32'(m_we));
                check($sformatf("rnd%0d.Writereg", cyc), 32'(bus.Writereg), 32'(m_reg));
                check($sformatf("rnd%0d.Writedata", cyc), bus.Writedata, m_data);
            end

            if (!r_in) begin
                m_ptr   = 0;
                m_we    = 1'b0;
                m_reg   = '0;
                m_data  = '0;
                m_known = 1'b1;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                m_we  = (ra[g] != 5'd0);
                if (m_we) begin
                    m_reg  = ra[g];
                    m_data = rd[g];
                end
                rv[g] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
